axil_wb_bridge_arb: RTL and testbench

Parametrised AXI4-Lite slave to classic Wishbone master bridge, the successor to the single-width bridge in the core wrappers.
- Sits between an AXI4-Lite core and the Controller's Wishbone memory port.
- Adds DATA_WIDTH generalisation (32/64), independent AW/W/AR holding registers and fair read/write arbitration.
- Maps Wishbone error to SLVERR; adds an optional bus timeout that returns DECERR.

---
 rtl/axil_wb_pkg.sv | 23 ++
 rtl/axil_wb_hold_reg.sv | 46 ++++
 rtl/axil_wb_bridge_arb.sv | 204 ++++++++++++++++++++
 tb/tb_axil_wb_bridge_arb.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_wb_pkg.sv
// Shared types and helpers for the AXI4-Lite to Wishbone bridge.
package axil_wb_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_BUS,
    RD_BUS,
    WR_RESP,
    RD_RESP
  } bridge_state_t;

  function automatic int strb_bits(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axil_wb_hold_reg.sv
// One-entry valid/ready holding register; ready is registered and low during reset.
module axil_wb_hold_reg
  import axil_wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic full_d;
  logic take;

  assign take = valid && ready;

  // clear and take never coincide because ready is low whenever full is high
  always_comb begin
    full_d = full;
    if (clear) begin
      full_d = 1'b0;
    end else if (take) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full  <= 1'b0;
      ready <= 1'b0;
      data  <= '0;
    end else begin
      full  <= full_d;
      ready <= !full_d;
      if (take) begin
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/axil_wb_bridge_arb.sv
// AXI4-Lite slave to classic Wishbone master bridge with fair read/write arbitration.
// Optional bus timeout returning DECERR is enabled by defining AXIL_WB_TIMEOUT_EN.
module axil_wb_bridge_arb
  import axil_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STRB_WIDTH    = strb_bits(DATA_WIDTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  output logic [STRB_WIDTH-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam int LSB = $clog2(STRB_WIDTH);

  logic                  aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  clr_wr, clr_rd;
  logic                  timeout, bus_done;

  bridge_state_t         state, state_d;
  logic                  prio_rd, prio_d;
  logic                  cyc_d, we_d, bvalid_d, rvalid_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [DATA_WIDTH-1:0] dat_d, rdata_d;
  logic [STRB_WIDTH-1:0] sel_d;
  resp_t                 bresp_q, bresp_d, rresp_q, rresp_d;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  axil_wb_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk(ACLK), .rst_n(ARESETN), .valid(AWVALID), .ready(AWREADY),
    .load_data(AWADDR), .clear(clr_wr), .full(aw_full), .data(aw_addr)
  );

  axil_wb_hold_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
    .clk(ACLK), .rst_n(ARESETN), .valid(WVALID), .ready(WREADY),
    .load_data({WSTRB, WDATA}), .clear(clr_wr), .full(w_full), .data({w_strb, w_data})
  );

  axil_wb_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
    .clk(ACLK), .rst_n(ARESETN), .valid(ARVALID), .ready(ARREADY),
    .load_data(ARADDR), .clear(clr_rd), .full(ar_full), .data(ar_addr)
  );

`ifdef AXIL_WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) + 1 > 16) ? $clog2(TIMEOUT_CYCLES) + 1 : 16;
  logic [CNT_W-1:0] to_cnt;

  // counts cycles of the current bus cycle; zero whenever cyc is low
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      to_cnt <= '0;
    end else if (wb_cyc_o) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout = wb_cyc_o && !wb_ack_i && !wb_err_i && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign bus_done = wb_cyc_o && (wb_ack_i || wb_err_i || timeout);
  assign BRESP    = bresp_q;
  assign RRESP    = rresp_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= IDLE;
      prio_rd  <= 1'b1;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      BVALID   <= 1'b0;
      bresp_q  <= OKAY;
      RVALID   <= 1'b0;
      rresp_q  <= OKAY;
      RDATA    <= '0;
    end else begin
      state    <= state_d;
      prio_rd  <= prio_d;
      wb_cyc_o <= cyc_d;
      wb_stb_o <= cyc_d;
      wb_we_o  <= we_d;
      wb_adr_o <= adr_d;
      wb_dat_o <= dat_d;
      wb_sel_o <= sel_d;
      BVALID   <= bvalid_d;
      bresp_q  <= bresp_d;
      RVALID   <= rvalid_d;
      rresp_q  <= rresp_d;
      RDATA    <= rdata_d;
    end
  end

  // Wishbone signals are zero outside a bus cycle; the first bus-state cycle only loads them
  always_comb begin
    state_d  = state;
    prio_d   = prio_rd;
    cyc_d    = 1'b0;
    we_d     = 1'b0;
    adr_d    = '0;
    dat_d    = '0;
    sel_d    = '0;
    bvalid_d = BVALID;
    bresp_d  = bresp_q;
    rvalid_d = RVALID;
    rresp_d  = rresp_q;
    rdata_d  = RDATA;
    clr_wr   = 1'b0;
    clr_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (ar_full && (!(aw_full && w_full) || prio_rd)) begin
          state_d = RD_BUS;
          prio_d  = 1'b0;
        end else if (aw_full && w_full) begin
          state_d = WR_BUS;
          prio_d  = 1'b1;
        end
      end
      WR_BUS: begin
        if (bus_done) begin
          state_d  = WR_RESP;
          clr_wr   = 1'b1;
          bvalid_d = 1'b1;
          bresp_d  = wb_err_i ? SLVERR : (wb_ack_i ? OKAY : DECERR);
        end else begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          adr_d = {aw_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
          dat_d = w_data;
          sel_d = w_strb;
        end
      end
      RD_BUS: begin
        if (bus_done) begin
          state_d  = RD_RESP;
          clr_rd   = 1'b1;
          rvalid_d = 1'b1;
          rresp_d  = wb_err_i ? SLVERR : (wb_ack_i ? OKAY : DECERR);
          rdata_d  = (wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
        end else begin
          cyc_d = 1'b1;
          adr_d = {ar_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
          sel_d = '1;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_RESP: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_wb_bridge_arb.sv
// Directed bench for axil_wb_bridge_arb: a queue model of expected bus cycles and responses.
// The timeout scenario is compiled only when AXIL_WB_TIMEOUT_EN is defined.
module tb_axil_wb_bridge_arb;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;
  logic [3:0]  wb_sel_o;

  logic [31:0] awaddr_w = '0, araddr_w = '0, wb_adr_w;
  logic [63:0] wdata_w = '0, rdata_w, wb_dat_o_w, wb_dat_i_w = '0;
  logic [7:0]  wstrb_w = '0, wb_sel_w;
  logic        awvalid_w = 0, awready_w, wvalid_w = 0, wready_w, bvalid_w, bready_w = 0;
  logic        arvalid_w = 0, arready_w, rvalid_w, rready_w = 0;
  logic        wb_we_w, wb_stb_w, wb_cyc_w, wb_ack_w = 0, wb_err_w = 0;
  logic [1:0]  bresp_w, rresp_w;

  always #5 ACLK = ~ACLK;

  axil_wb_bridge_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  axil_wb_bridge_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut_wide (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(awaddr_w), .AWPROT(3'b000), .AWVALID(awvalid_w), .AWREADY(awready_w),
    .WDATA(wdata_w), .WSTRB(wstrb_w), .WVALID(wvalid_w), .WREADY(wready_w),
    .BRESP(bresp_w), .BVALID(bvalid_w), .BREADY(bready_w),
    .ARADDR(araddr_w), .ARPROT(3'b000), .ARVALID(arvalid_w), .ARREADY(arready_w),
    .RDATA(rdata_w), .RRESP(rresp_w), .RVALID(rvalid_w), .RREADY(rready_w),
    .wb_adr_o(wb_adr_w), .wb_dat_o(wb_dat_o_w), .wb_we_o(wb_we_w), .wb_stb_o(wb_stb_w),
    .wb_cyc_o(wb_cyc_w), .wb_sel_o(wb_sel_w), .wb_dat_i(wb_dat_i_w),
    .wb_ack_i(wb_ack_w), .wb_err_i(wb_err_w)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } bus_op_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  bus_op_t     exp_bus[$];
  logic [1:0]  exp_b[$];
  rsp_t        exp_r[$];

  int          total = 0;
  int          bad = 0;
  int          cyc_num = 0;
  int          last_hs = 0;
  int          cyc_start = 0;
  int          last_cyc_len = 0;
  int          ack_delay = 1;
  int          slave_mode = 0;
  logic [31:0] slave_rdata = '0;
  logic [31:0] last_rdata = '0;

  always @(posedge ACLK) cyc_num <= cyc_num + 1;

  function automatic bus_op_t wrOp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_op_t op;
    op.we  = 1'b1;
    op.adr = a & ~32'h3;
    op.sel = s;
    op.dat = d;
    return op;
  endfunction

  function automatic bus_op_t rdOp(input logic [31:0] a);
    bus_op_t op;
    op.we  = 1'b0;
    op.adr = a & ~32'h3;
    op.sel = 4'hF;
    op.dat = '0;
    return op;
  endfunction

  function automatic rsp_t rdRsp(input logic [1:0] r, input logic [31:0] d);
    rsp_t x;
    x.resp = r;
    x.data = d;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic sendAw(input logic [31:0] a);
    int n;
    AWADDR = a;
    AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("awready reached", AWREADY, 1);
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
    last_hs = cyc_num;
  endtask

  task automatic sendW(input logic [31:0] d, input logic [3:0] s);
    int n;
    WDATA = d;
    WSTRB = s;
    WVALID = 1'b1;
    n = 0;
    while (!WREADY && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("wready reached", WREADY, 1);
    @(posedge ACLK);
    #1;
    WVALID = 1'b0;
    last_hs = cyc_num;
  endtask

  task automatic sendAr(input logic [31:0] a);
    int n;
    ARADDR = a;
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("arready reached", ARREADY, 1);
    @(posedge ACLK);
    #1;
    ARVALID = 1'b0;
    last_hs = cyc_num;
  endtask

  // kind 0 issues AW and W together, kind 1 issues AR
  task automatic applyStimulus(input int kind, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
    if (kind == 0) begin
      fork
        sendAw(a);
        sendW(d, s);
      join
    end else begin
      sendAr(a);
    end
  endtask

  task automatic waitB(input int hold);
    int n;
    n = 0;
    while (!BVALID && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("bvalid arrives", BVALID, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      checkOutput("bvalid held", BVALID, 1);
    end
    BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("bvalid drops", BVALID, 0);
  endtask

  task automatic waitR(input int hold);
    int n;
    n = 0;
    while (!RVALID && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("rvalid arrives", RVALID, 1);
    last_rdata = RDATA;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      checkOutput("rvalid held", RVALID, 1);
    end
    RREADY = 1'b1;
    @(posedge ACLK);
    #1;
    RREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("rvalid drops", RVALID, 0);
  endtask

  task automatic resetDut();
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
  endtask

  // Wishbone slave: terminates after ack_delay cycles of cyc, per slave_mode (0 ack, 1 err, 2 both, 3 never)
  initial begin
    int scnt;
    scnt = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge ACLK);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o) begin
        scnt++;
        if (scnt == ack_delay) begin
          wb_dat_i = slave_rdata;
          case (slave_mode)
            0: wb_ack_i = 1'b1;
            1: wb_err_i = 1'b1;
            2: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
            default: ;
          endcase
        end
      end else begin
        scnt = 0;
      end
    end
  end

  bus_op_t    cur_op;
  logic [1:0] cur_b;
  rsp_t       cur_r;
  logic       prev_cyc = 0, prev_b = 0, prev_r = 0;
  int         cyc_len = 0;

  // compare process: every bus cycle and response is checked against the expectation queues
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        prev_cyc = 0;
        prev_b = 0;
        prev_r = 0;
        cyc_len = 0;
      end else begin
        if (wb_cyc_o) begin
          if (!prev_cyc) begin
            cyc_start = cyc_num;
            cyc_len = 0;
            checkOutput("bus cycle expected", exp_bus.size() > 0, 1);
            if (exp_bus.size() > 0) cur_op = exp_bus.pop_front();
          end
          cyc_len++;
          checkOutput("wb_stb_o", wb_stb_o, 1);
          checkOutput("wb_we_o", wb_we_o, cur_op.we);
          checkOutput("wb_adr_o", wb_adr_o, cur_op.adr);
          checkOutput("wb_sel_o", wb_sel_o, cur_op.sel);
          if (cur_op.we) checkOutput("wb_dat_o", wb_dat_o, cur_op.dat);
        end else if (prev_cyc) begin
          last_cyc_len = cyc_len;
        end
        if (BVALID) begin
          if (!prev_b) begin
            checkOutput("b response expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) cur_b = exp_b.pop_front();
          end
          checkOutput("BRESP", BRESP, cur_b);
        end
        if (RVALID) begin
          if (!prev_r) begin
            checkOutput("r response expected", exp_r.size() > 0, 1);
            if (exp_r.size() > 0) cur_r = exp_r.pop_front();
          end
          checkOutput("RRESP", RRESP, cur_r.resp);
          checkOutput("RDATA", RDATA, cur_r.data);
        end
        prev_cyc = wb_cyc_o;
        prev_b = BVALID;
        prev_r = RVALID;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge ACLK);
    checkOutput("reset AWREADY", AWREADY, 0);
    checkOutput("reset WREADY", WREADY, 0);
    checkOutput("reset ARREADY", ARREADY, 0);
    checkOutput("reset BVALID", BVALID, 0);
    checkOutput("reset RVALID", RVALID, 0);
    checkOutput("reset wb_cyc_o", wb_cyc_o, 0);
    checkOutput("reset wb_stb_o", wb_stb_o, 0);
    checkOutput("reset wb_we_o", wb_we_o, 0);
    checkOutput("reset wb_sel_o", wb_sel_o, 0);
    checkOutput("reset wb_adr_o", wb_adr_o, 0);
    checkOutput("reset RDATA", RDATA, 0);
    checkOutput("reset BRESP/RRESP", {BRESP, RRESP}, 0);
    checkOutput("reset wide AWREADY", awready_w, 0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    checkOutput("AWREADY after reset", AWREADY, 1);

    // single write, ack after 2 cycles, BVALID held for 3 cycles
    ack_delay = 2;
    slave_mode = 0;
    exp_bus.push_back(wrOp(32'h1000_0004, 32'hDEAD_BEEF, 4'b0011));
    exp_b.push_back(2'b00);
    applyStimulus(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011);
    n = 0;
    while (!wb_cyc_o && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("T1 literal adr", wb_adr_o, 32'h1000_0004);
    checkOutput("T1 literal sel", wb_sel_o, 4'b0011);
    checkOutput("T1 literal we", wb_we_o, 1);
    checkOutput("T1 issue latency", cyc_start - last_hs, 2);
    waitB(3);
    checkOutput("T1 cyc length", last_cyc_len, 2);

    // W leads AW by 3 cycles, then a read
    ack_delay = 1;
    slave_rdata = 32'hCAFE_F00D;
    exp_bus.push_back(wrOp(32'h0000_0100, 32'h1234_5678, 4'hF));
    exp_bus.push_back(rdOp(32'h0000_0020));
    exp_b.push_back(2'b00);
    exp_r.push_back(rdRsp(2'b00, 32'hCAFE_F00D));
    fork
      sendW(32'h1234_5678, 4'hF);
      begin
        repeat (3) @(negedge ACLK);
        sendAw(32'h0000_0100);
      end
    join
    sendAr(32'h0000_0020);
    fork
      waitB(0);
      waitR(2);
    join
    checkOutput("T2 literal rdata", last_rdata, 32'hCAFE_F00D);

    // AW, W and AR in the same cycle: read first, then a refilled AR loses to the pending write
    resetDut();
    slave_rdata = 32'h1111_2222;
    exp_bus.push_back(rdOp(32'h0000_0040));
    exp_bus.push_back(wrOp(32'h0000_0080, 32'h55AA_55AA, 4'b1100));
    exp_bus.push_back(rdOp(32'h0000_00C0));
    exp_r.push_back(rdRsp(2'b00, 32'h1111_2222));
    exp_b.push_back(2'b00);
    exp_r.push_back(rdRsp(2'b00, 32'h1111_2222));
    fork
      sendAw(32'h0000_0080);
      sendW(32'h55AA_55AA, 4'b1100);
      sendAr(32'h0000_0040);
    join
    fork
      sendAr(32'h0000_00C0);
      waitR(1);
    join
    fork
      waitB(0);
      waitR(0);
    join

    // simultaneous err and ack on a read, then err alone on a write
    slave_mode = 2;
    slave_rdata = 32'hBAD0_BAD0;
    exp_bus.push_back(rdOp(32'h0000_0044));
    exp_r.push_back(rdRsp(2'b10, 32'h0));
    applyStimulus(1, 32'h0000_0044, 32'h0, 4'h0);
    waitR(0);
    checkOutput("T4 literal rdata on err", last_rdata, 32'h0);
    slave_mode = 1;
    exp_bus.push_back(wrOp(32'h0000_0048, 32'hA0A0_A0A0, 4'hF));
    exp_b.push_back(2'b10);
    applyStimulus(0, 32'h0000_0048, 32'hA0A0_A0A0, 4'hF);
    waitB(1);

    // zero-strobe write still runs a bus cycle and responds OKAY
    slave_mode = 0;
    exp_bus.push_back(wrOp(32'h0000_0203, 32'h0BAD_CAFE, 4'h0));
    exp_b.push_back(2'b00);
    applyStimulus(0, 32'h0000_0203, 32'h0BAD_CAFE, 4'h0);
    waitB(0);

    // 64-bit instance: low address bits forced to zero, byte selects follow WSTRB
    @(negedge ACLK);
    awaddr_w = 32'h0000_000F;
    wdata_w = 64'h0123_4567_89AB_CDEF;
    wstrb_w = 8'hF0;
    awvalid_w = 1'b1;
    wvalid_w = 1'b1;
    n = 0;
    while (!(awready_w && wready_w) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("wide ready", awready_w && wready_w, 1);
    @(posedge ACLK);
    #1;
    awvalid_w = 1'b0;
    wvalid_w = 1'b0;
    n = 0;
    while (!wb_cyc_w && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("wide wb_adr_o", wb_adr_w, 32'h0000_0008);
    checkOutput("wide wb_sel_o", wb_sel_w, 8'hF0);
    checkOutput("wide wb_we_o", wb_we_w, 1);
    checkOutput("wide wb_dat_o", wb_dat_o_w, 64'h0123_4567_89AB_CDEF);
    wb_ack_w = 1'b1;
    @(negedge ACLK);
    wb_ack_w = 1'b0;
    checkOutput("wide cyc dropped", wb_cyc_w, 0);
    checkOutput("wide bvalid", bvalid_w, 1);
    checkOutput("wide bresp", bresp_w, 2'b00);
    bready_w = 1'b1;
    @(posedge ACLK);
    #1;
    bready_w = 1'b0;

`ifdef AXIL_WB_TIMEOUT_EN
    // slave never answers: cyc stays high for TIMEOUT_CYCLES=8 cycles and DECERR returns
    slave_mode = 3;
    slave_rdata = 32'h7777_7777;
    exp_bus.push_back(wrOp(32'h0000_0300, 32'h0000_0077, 4'hF));
    exp_b.push_back(2'b11);
    applyStimulus(0, 32'h0000_0300, 32'h0000_0077, 4'hF);
    waitB(0);
    checkOutput("timeout cyc length", last_cyc_len, 8);
    exp_bus.push_back(rdOp(32'h0000_0304));
    exp_r.push_back(rdRsp(2'b11, 32'h0));
    applyStimulus(1, 32'h0000_0304, 32'h0, 4'h0);
    waitR(0);
    checkOutput("timeout read cyc length", last_cyc_len, 8);
`endif

    // reset in the middle of a bus cycle drops it without a response
    slave_mode = 3;
    exp_bus.push_back(wrOp(32'h0000_0400, 32'hFEED_FACE, 4'hF));
    applyStimulus(0, 32'h0000_0400, 32'hFEED_FACE, 4'hF);
    n = 0;
    while (!wb_cyc_o && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    @(negedge ACLK);
    checkOutput("cyc before mid reset", wb_cyc_o, 1);
    ARESETN = 1'b0;
    @(posedge ACLK);
    #1;
    checkOutput("mid reset wb_cyc_o", wb_cyc_o, 0);
    checkOutput("mid reset wb_stb_o", wb_stb_o, 0);
    checkOutput("mid reset wb_we_o", wb_we_o, 0);
    checkOutput("mid reset readies", {AWREADY, WREADY, ARREADY}, 0);
    checkOutput("mid reset valids", {BVALID, RVALID}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    slave_mode = 0;
    repeat (10) @(negedge ACLK);
    checkOutput("no response after reset", {BVALID, RVALID, wb_cyc_o}, 0);

    checkOutput("bus expectations drained", exp_bus.size(), 0);
    checkOutput("b expectations drained", exp_b.size(), 0);
    checkOutput("r expectations drained", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
